// File: rtl/jtkicker_sdram_resp_pkg.sv
// ----------------------------------------------------------------------------
// jtkicker_sdram_resp_pkg : shared types and constants for the SDRAM responder
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package jtkicker_sdram_resp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR     = 3'd1,
    ST_RDWAIT = 3'd2,
    ST_DST    = 3'd3,
    ST_RDY    = 3'd4
  } state_t;

  localparam int          SDRAM_AW = 22;
  localparam logic [15:0] OOR_FILL = 16'hFFFF;

  // True when every address bit at or above aw is zero.
  function automatic logic addr_in_range(input logic [SDRAM_AW-1:0] addr, input int aw);
    return (addr >> aw) == '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jtkicker_sdram_resp_if.sv
// ----------------------------------------------------------------------------
// jtkicker_sdram_resp_if : game-side SDRAM bus (download writes + slot reads)
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface jtkicker_sdram_resp_if;
  import jtkicker_sdram_resp_pkg::*;

  logic                downloading;
  logic [SDRAM_AW-1:0] prog_addr;
  logic [7:0]          prog_data;
  logic [1:0]          prog_mask;
  logic                prog_we;
  logic                sdram_req;
  logic [SDRAM_AW-1:0] sdram_addr;
  logic                sdram_ack;
  logic                data_dst;
  logic                data_rdy;
  logic [15:0]         data_read;

  modport master (
    output downloading, prog_addr, prog_data, prog_mask, prog_we,
    output sdram_req, sdram_addr,
    input  sdram_ack, data_dst, data_rdy, data_read
  );

  modport slave (
    input  downloading, prog_addr, prog_data, prog_mask, prog_we,
    input  sdram_req, sdram_addr,
    output sdram_ack, data_dst, data_rdy, data_read
  );

endinterface

`default_nettype wire

// File: rtl/jtkicker_resp_ram.sv
// ----------------------------------------------------------------------------
// jtkicker_resp_ram : single-port 16-bit RAM, per-byte write, registered read
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module jtkicker_resp_ram #(
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   din,
  input  logic [1:0]    we,
  input  logic          re,
  output logic [15:0]   q
);

  // One independent byte array per lane keeps each lane a plain BRAM.
  for (genvar i = 0; i < 2; i++) begin : g_lane
    logic [7:0] mem [0:(2**AW)-1];
    logic [7:0] q_lane;

    always_ff @(posedge clk) begin
      if (we[i]) mem[addr] <= din[8*i +: 8];
      if (re)    q_lane    <= mem[addr];
    end

    assign q[8*i +: 8] = q_lane;
  end

endmodule

`default_nettype wire

// File: rtl/jtkicker_sdram_resp.sv
// ----------------------------------------------------------------------------
// jtkicker_sdram_resp : block-RAM responder for the Kicker game SDRAM bus
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module jtkicker_sdram_resp
  import jtkicker_sdram_resp_pkg::*;
#(
  parameter int AW      = 17,
  parameter int LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  jtkicker_sdram_resp_if.slave   bus
);

  state_t        state, state_nx;
  logic [3:0]    cnt, cnt_nx;
  logic          ack_nx, dst_nx, rdy_nx;
  logic          wr_go, rd_go;
  logic          oor;
  logic          wr_in, rd_in;
  logic [AW-1:0] ram_addr;
  logic [1:0]    ram_we;
  logic          ram_re;
  logic [15:0]   ram_q;

  assign wr_in = addr_in_range(bus.prog_addr,  AW);
  assign rd_in = addr_in_range(bus.sdram_addr, AW);

  // The RAM port is only touched in the acceptance cycle; reset suppresses it.
  assign ram_addr = wr_go ? bus.prog_addr[AW-1:0] : bus.sdram_addr[AW-1:0];
  assign ram_we   = (wr_go && wr_in && !rst) ? ~bus.prog_mask : 2'b00;
  assign ram_re   = rd_go && !rst;

  jtkicker_resp_ram #(.AW(AW)) u_ram (
    .clk  (clk),
    .addr (ram_addr),
    .din  ({bus.prog_data, bus.prog_data}),
    .we   (ram_we),
    .re   (ram_re),
    .q    (ram_q)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ack_nx   = 1'b0;
    dst_nx   = 1'b0;
    rdy_nx   = 1'b0;
    wr_go    = 1'b0;
    rd_go    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.prog_we) begin
          wr_go    = 1'b1;
          ack_nx   = 1'b1;
          state_nx = ST_WR;
        end else if (bus.sdram_req && !bus.downloading) begin
          rd_go    = 1'b1;
          ack_nx   = 1'b1;
          cnt_nx   = 4'(LATENCY - 1);
          state_nx = ST_RDWAIT;
        end
      end
      ST_WR: state_nx = ST_IDLE;
      ST_RDWAIT: begin
        if (cnt == 4'd0) begin
          dst_nx   = 1'b1;
          state_nx = ST_DST;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      ST_DST: begin
        rdy_nx   = 1'b1;
        state_nx = ST_RDY;
      end
      ST_RDY:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= 4'd0;
      oor           <= 1'b0;
      bus.sdram_ack <= 1'b0;
      bus.data_dst  <= 1'b0;
      bus.data_rdy  <= 1'b0;
      bus.data_read <= 16'h0000;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      bus.sdram_ack <= ack_nx;
      bus.data_dst  <= dst_nx;
      bus.data_rdy  <= rdy_nx;
      if (rd_go)  oor           <= !rd_in;
      if (dst_nx) bus.data_read <= oor ? OOR_FILL : ram_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jtkicker_sdram_resp.sv
// ----------------------------------------------------------------------------
// tb_jtkicker_sdram_resp : directed scoreboard bench for the SDRAM responder
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_jtkicker_sdram_resp;

  localparam int AW  = 17;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jtkicker_sdram_resp_if bus();

  jtkicker_sdram_resp #(.AW(AW), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          compared   = 0;
  int          mismatched = 0;
  logic [15:0] sb [$];
  logic        prev_dst   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every data_dst.
  always @(negedge clk) begin
    if (bus.data_dst) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_dst: got data_dst=1 data_read=%0h expected no dst at %0t",
                 bus.data_read, $time);
      end else begin
        check("rd_data", {16'h0, bus.data_read}, {16'h0, sb.pop_front()});
      end
    end
    if (bus.data_rdy) check("rdy_after_dst", {31'h0, prev_dst}, 32'h1);
    prev_dst = bus.data_dst;
  end

  // Caller is at a negedge with the DUT idle.
  task automatic do_write(input logic [21:0] a, input logic [7:0] d, input logic [1:0] m);
    bus.prog_addr = a;
    bus.prog_data = d;
    bus.prog_mask = m;
    bus.prog_we   = 1'b1;
    @(negedge clk);
    check("wr_ack", {31'h0, bus.sdram_ack}, 32'h1);
    bus.prog_we = 1'b0;
    @(negedge clk);
    check("wr_ack_width", {31'h0, bus.sdram_ack}, 32'h0);
  endtask

  task automatic do_read(input logic [21:0] a, input logic [15:0] exp);
    sb.push_back(exp);
    bus.sdram_addr = a;
    bus.sdram_req  = 1'b1;
    @(negedge clk);
    check("rd_ack", {31'h0, bus.sdram_ack}, 32'h1);
    bus.sdram_req = 1'b0;
    repeat (LAT) @(negedge clk);
    check("rd_dst_time", {31'h0, bus.data_dst}, 32'h1);
    @(negedge clk);
    check("rd_rdy_time", {30'h0, bus.data_rdy, bus.data_dst}, 32'h2);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic seen;
    bus.downloading = 1'b0;
    bus.prog_addr   = '0;
    bus.prog_data   = '0;
    bus.prog_mask   = 2'b11;
    bus.prog_we     = 1'b0;
    bus.sdram_req   = 1'b0;
    bus.sdram_addr  = '0;

    repeat (3) @(negedge clk);
    check("rst_ack",  {31'h0, bus.sdram_ack}, 32'h0);
    check("rst_dst",  {31'h0, bus.data_dst},  32'h0);
    check("rst_rdy",  {31'h0, bus.data_rdy},  32'h0);
    check("rst_data", {16'h0, bus.data_read}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Masked byte writes combine into one word
    do_write(22'h10, 8'hA5, 2'b10);
    do_write(22'h10, 8'h3C, 2'b01);
    do_read(22'h10, 16'h3CA5);
    repeat (2) @(negedge clk);
    check("data_hold", {16'h0, bus.data_read}, 32'h3CA5);

    do_write(22'h1FFFF, 8'h5A, 2'b00);
    do_write(22'h0,     8'h77, 2'b00);
    do_read(22'h1FFFF, 16'h5A5A);
    do_read(22'h0,     16'h7777);

    // Write and read raised together: write first, read acked two cycles later
    sb.push_back(16'h1111);
    bus.prog_addr  = 22'h20;
    bus.prog_data  = 8'h11;
    bus.prog_mask  = 2'b00;
    bus.prog_we    = 1'b1;
    bus.sdram_addr = 22'h20;
    bus.sdram_req  = 1'b1;
    @(negedge clk);
    check("coll_wr_ack", {31'h0, bus.sdram_ack}, 32'h1);
    bus.prog_we = 1'b0;
    @(negedge clk);
    check("coll_gap", {31'h0, bus.sdram_ack}, 32'h0);
    @(negedge clk);
    check("coll_rd_ack", {31'h0, bus.sdram_ack}, 32'h1);
    bus.sdram_req = 1'b0;
    repeat (LAT + 2) @(negedge clk);

    // Read held off by download
    sb.push_back(16'h3CA5);
    bus.downloading = 1'b1;
    bus.sdram_addr  = 22'h10;
    bus.sdram_req   = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.sdram_ack) seen = 1'b1;
    end
    check("dl_block", {31'h0, seen}, 32'h0);
    bus.downloading = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 4) begin
      @(negedge clk);
      n++;
      seen = bus.sdram_ack;
    end
    bus.sdram_req = 1'b0;
    check("dl_ack_latency_ok", {31'h0, (seen && n >= 1 && n <= 2)}, 32'h1);
    repeat (LAT + 2) @(negedge clk);

    // Out-of-range accesses
    do_read(22'h3FFFFF, 16'hFFFF);
    do_write(22'h20000, 8'h99, 2'b00);
    do_read(22'h0, 16'h7777);

    // Reset while waiting in RDWAIT aborts the read
    bus.sdram_addr = 22'h1FFFF;
    bus.sdram_req  = 1'b1;
    @(negedge clk);
    check("abort_ack", {31'h0, bus.sdram_ack}, 32'h1);
    bus.sdram_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("abort_outs", {13'h0, bus.sdram_ack, bus.data_dst, bus.data_rdy, bus.data_read}, 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    do_read(22'h1FFFF, 16'h5A5A);

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
